// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the operation encoding.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } alu_op_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/SUB; unknown op codes produce a zero result.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    // Select the operation; ADD/SUB wrap modulo 2^XLEN, anything unrecognised yields 0.
    always_comb begin
        result = '0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU with a single registered response slot.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [XLEN-1:0] resp_result,
    output logic            resp_zero
);

    logic            last_grant;
    logic            grant;
    logic            grant_valid;
    logic            can_accept;
    logic            handshake;
    logic [3:0]      sel_op;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    // Pick a requester: a lone valid wins, contention goes to whoever was not served last.
    always_comb begin
        grant_valid = req0_valid || req1_valid;
        grant       = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        can_accept = !resp_valid || resp_ready;
        req0_ready = !rst && can_accept && grant_valid && (grant == 1'b0);
        req1_ready = !rst && can_accept && grant_valid && (grant == 1'b1);
        handshake  = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        sel_op     = grant ? req1_op : req0_op;
        sel_a      = grant ? req1_a  : req0_a;
        sel_b      = grant ? req1_b  : req0_b;
    end

    alu u_alu (
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Response slot: load on handshake, drop valid once consumed, hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_id     <= 1'b0;
            last_grant  <= ~FIRST_PRIO;
        end else if (handshake) begin
            resp_valid  <= 1'b1;
            resp_result <= alu_result;
            resp_zero   <= alu_zero;
            resp_id     <= grant;
            last_grant  <= grant;
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: vector table plus multi-cycle corner sequences.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_result;
    logic        resp_zero;

    int errors;
    int checks;

    typedef struct {
        logic        id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[10];

    alu_arbiter #(.FIRST_PRIO(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_op     (req0_op),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_op     (req1_op),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v0, input logic [3:0] op0, input logic [31:0] a0,
                                 input logic [31:0] b0, input logic v1, input logic [3:0] op1,
                                 input logic [31:0] a1, input logic [31:0] b1, input logic rr);
        req0_valid = v0;
        req0_op    = op0;
        req0_a     = a0;
        req0_b     = b0;
        req1_valid = v1;
        req1_op    = op1;
        req1_a     = a1;
        req1_b     = b1;
        resp_ready = rr;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkReady(input string name, input logic r0, input logic r1);
        checkOutput({name, " ready0"}, {31'd0, req0_ready}, {31'd0, r0});
        checkOutput({name, " ready1"}, {31'd0, req1_ready}, {31'd0, r1});
    endtask

    task automatic checkResp(input string name, input logic v, input logic id,
                             input logic [31:0] res, input logic z);
        checkOutput({name, " valid"},  {31'd0, resp_valid}, {31'd0, v});
        checkOutput({name, " id"},     {31'd0, resp_id},    {31'd0, id});
        checkOutput({name, " result"}, resp_result,         res);
        checkOutput({name, " zero"},   {31'd0, resp_zero},  {31'd0, z});
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;

        vecs[0] = '{1'b0, 4'b0010, 32'd5,          32'd6,          32'd11,         1'b0};
        vecs[1] = '{1'b1, 4'b0000, 32'hffffffff,   32'h00ff00ff,   32'h00ff00ff,   1'b0};
        vecs[2] = '{1'b0, 4'b0001, 32'h0f0f0000,   32'h0000f0f0,   32'h0f0ff0f0,   1'b0};
        vecs[3] = '{1'b1, 4'b0010, 32'hffffffff,   32'd1,          32'd0,          1'b1};
        vecs[4] = '{1'b0, 4'b0110, 32'd0,          32'd1,          32'hffffffff,   1'b0};
        vecs[5] = '{1'b1, 4'b0110, 32'd555121,     32'd555121,     32'd0,          1'b1};
        vecs[6] = '{1'b0, 4'b1110, 32'd5,          32'd2222,       32'd0,          1'b1};
        vecs[7] = '{1'b1, 4'b0011, 32'd7,          32'd8,          32'd0,          1'b1};
        vecs[8] = '{1'b0, 4'b0010, 32'h80000000,   32'h80000000,   32'd0,          1'b1};
        vecs[9] = '{1'b1, 4'b0110, 32'd10,         32'd3,          32'd7,          1'b0};

        // Reset with both requesters asking: nothing may be granted while reset is high.
        rst = 1'b1;
        applyStimulus(1'b1, 4'b0010, 32'd1, 32'd1, 1'b1, 4'b0010, 32'd2, 32'd2, 1'b1);
        checkReady("in reset", 1'b0, 1'b0);
        cycle();
        cycle();
        applyStimulus(1'b0, 4'b0, 32'd0, 32'd0, 1'b0, 4'b0, 32'd0, 32'd0, 1'b1);
        rst = 1'b0;
        checkResp("reset state", 1'b0, 1'b0, 32'd0, 1'b0);

        // Contention straight after reset: requester 0 first, then 1.
        applyStimulus(1'b1, 4'b0110, 32'h80000000, 32'd1, 1'b1, 4'b0000, 32'hffffffff, 32'h00ff00ff, 1'b1);
        checkReady("contend 1st", 1'b1, 1'b0);
        cycle();
        checkResp("contend 1st", 1'b1, 1'b0, 32'h7fffffff, 1'b0);
        applyStimulus(1'b1, 4'b0010, 32'd9, 32'd9, 1'b1, 4'b0000, 32'hffffffff, 32'h00ff00ff, 1'b1);
        checkReady("contend 2nd", 1'b0, 1'b1);
        cycle();
        checkResp("contend 2nd", 1'b1, 1'b1, 32'h00ff00ff, 1'b0);
        applyStimulus(1'b0, 4'b0, 32'd0, 32'd0, 1'b0, 4'b0, 32'd0, 32'd0, 1'b1);
        cycle();
        checkResp("drain", 1'b0, 1'b1, 32'h00ff00ff, 1'b0);

        // Continuous contention: grants alternate 0,1,0,1 at one response per cycle.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 4'b0010, 32'h100, 32'd0, 1'b1, 4'b0001, 32'h200, 32'd0, 1'b1);
            checkReady($sformatf("rr %0d", i), (i % 2) == 0, (i % 2) == 1);
            cycle();
            checkResp($sformatf("rr %0d", i), 1'b1, (i % 2) == 1,
                      ((i % 2) == 0) ? 32'h100 : 32'h200, 1'b0);
        end
        applyStimulus(1'b0, 4'b0, 32'd0, 32'd0, 1'b0, 4'b0, 32'd0, 32'd0, 1'b1);
        cycle();

        // Backpressure on a zero result; stalled requester changes its inputs while not ready.
        applyStimulus(1'b1, 4'b0110, 32'd555121, 32'd555121, 1'b0, 4'b0, 32'd0, 32'd0, 1'b1);
        cycle();
        checkResp("bp load", 1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b0, 32'd0, 32'd0, 1'b1, 4'b0001, 32'hdead0000 + i, 32'hbeef, 1'b0);
            checkReady($sformatf("bp stall %0d", i), 1'b0, 1'b0);
            cycle();
            checkResp($sformatf("bp stall %0d", i), 1'b1, 1'b0, 32'd0, 1'b1);
        end
        applyStimulus(1'b0, 4'b0, 32'd0, 32'd0, 1'b1, 4'b0010, 32'd3, 32'd4, 1'b1);
        checkReady("bp release", 1'b0, 1'b1);
        cycle();
        checkResp("bp release", 1'b1, 1'b1, 32'd7, 1'b0);

        // Table of single-requester operations, back to back.
        foreach (vecs[k]) begin
            if (vecs[k].id == 1'b0)
                applyStimulus(1'b1, vecs[k].op, vecs[k].a, vecs[k].b, 1'b0, 4'b0, 32'd0, 32'd0, 1'b1);
            else
                applyStimulus(1'b0, 4'b0, 32'd0, 32'd0, 1'b1, vecs[k].op, vecs[k].a, vecs[k].b, 1'b1);
            checkReady($sformatf("vec %0d", k), vecs[k].id == 1'b0, vecs[k].id == 1'b1);
            cycle();
            checkResp($sformatf("vec %0d", k), 1'b1, vecs[k].id, vecs[k].exp_result, vecs[k].exp_zero);
        end

        // Reset while a response is stalled: the response is discarded, priority restarts at 0.
        applyStimulus(1'b0, 4'b0, 32'd0, 32'd0, 1'b1, 4'b0010, 32'd1, 32'd1, 1'b1);
        cycle();
        applyStimulus(1'b1, 4'b0010, 32'd4, 32'd4, 1'b1, 4'b0010, 32'd8, 32'd8, 1'b0);
        cycle();
        checkResp("pre reset", 1'b1, 1'b1, 32'd2, 1'b0);
        rst = 1'b1;
        #1;
        checkReady("mid reset", 1'b0, 1'b0);
        cycle();
        rst = 1'b0;
        checkResp("post reset", 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 4'b0010, 32'd4, 32'd4, 1'b1, 4'b0010, 32'd8, 32'd8, 1'b1);
        checkReady("post reset grant", 1'b1, 1'b0);
        cycle();
        checkResp("post reset grant", 1'b1, 1'b0, 32'd8, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
